// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS core: control-bundle layout,
// instruction field positions and ALU operation encodings.
package cpu_pkg;

  localparam int CTRL_WIDTH       = 12;
  localparam int CTRL_REGWRITE    = 11;
  localparam int CTRL_MEMREAD     = 10;
  localparam int CTRL_MEMWRITE    = 9;
  localparam int CTRL_MEMTOREG    = 8;
  localparam int CTRL_ALUSRC      = 7;
  localparam int CTRL_REGDST      = 6;
  localparam int CTRL_ALUOP_HI    = 5;
  localparam int CTRL_ALUOP_LO    = 2;
  localparam int CTRL_BRANCH      = 1;
  localparam int CTRL_USESRT      = 0;

  localparam int INSTR_RS_HI      = 25;
  localparam int INSTR_RS_LO      = 21;
  localparam int INSTR_RT_HI      = 20;
  localparam int INSTR_RT_LO      = 16;
  localparam int INSTR_RD_HI      = 15;
  localparam int INSTR_RD_LO      = 11;
  localparam int INSTR_SHAMT_HI   = 10;
  localparam int INSTR_SHAMT_LO   = 6;
  localparam int INSTR_IMM_HI     = 15;
  localparam int INSTR_IMM_LO     = 0;
  localparam int REG_IDX_W        = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11,
    ALU_FUNC = 4'd15
  } alu_op_e;

  // Even parity over a control bundle, for downstream integrity checks.
  function automatic logic ctrl_parity(input logic [CTRL_WIDTH-1:0] ctrl);
    return ^ctrl;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a load currently in EX. Also reused by branch-in-ID logic.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic                 ex_valid_i,
  input  logic                 ex_memread_i,
  input  logic [REG_IDX_W-1:0] ex_rt_i,
  input  logic                 id_valid_i,
  input  logic [REG_IDX_W-1:0] id_rs_i,
  input  logic [REG_IDX_W-1:0] id_rt_i,
  input  logic                 id_uses_rt_i,
  input  logic                 flush_i,
  output logic                 hazard_o,
  output logic                 stall_o
);

  logic rs_match_s;
  logic rt_match_s;

  // Operand match against the load destination; $0 never creates a dependency.
  always_comb begin
    rs_match_s = (ex_rt_i == id_rs_i);
    rt_match_s = (ex_rt_i == id_rt_i) && id_uses_rt_i;
    hazard_o   = ex_valid_i && ex_memread_i && id_valid_i &&
                 (ex_rt_i != 5'd0) && (rs_match_s || rt_match_s);
    stall_o    = hazard_o && !flush_i;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle WB bypass into the ID operands and
// a one-bubble load-use interlock.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int CTRL_W           = CTRL_WIDTH,
  parameter int CTRL_MEMREAD_BIT = CTRL_MEMREAD,
  parameter int CTRL_USESRT_BIT  = CTRL_USESRT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [31:0]       id_pc4,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_ext_op,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_shamt
);

  logic [4:0]        id_rs_s, id_rt_s, id_rd_s, id_shamt_s;
  logic [DATA_W-1:0] rs_val_s, rt_val_s, imm_s;
  logic              hazard_s;
  logic              unused_opcode_s;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       pc4_q;
  logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
  logic [4:0]        rs_q, rt_q, rd_q, shamt_q;

  assign id_rs_s         = id_instr[INSTR_RS_HI:INSTR_RS_LO];
  assign id_rt_s         = id_instr[INSTR_RT_HI:INSTR_RT_LO];
  assign id_rd_s         = id_instr[INSTR_RD_HI:INSTR_RD_LO];
  assign id_shamt_s      = id_instr[INSTR_SHAMT_HI:INSTR_SHAMT_LO];
  assign unused_opcode_s = ^id_instr[31:26];

  // The register file writes on the same edge we capture, so forward WB here.
  always_comb begin
    if (id_rs_s == 5'd0) begin
      rs_val_s = '0;
    end else if (wb_reg_write && (wb_write_reg == id_rs_s)) begin
      rs_val_s = wb_write_data;
    end else begin
      rs_val_s = rf_data1;
    end
    if (id_rt_s == 5'd0) begin
      rt_val_s = '0;
    end else if (wb_reg_write && (wb_write_reg == id_rt_s)) begin
      rt_val_s = wb_write_data;
    end else begin
      rt_val_s = rf_data2;
    end
    imm_s = {{(DATA_W-16){id_ext_op & id_instr[15]}}, id_instr[INSTR_IMM_HI:INSTR_IMM_LO]};
  end

  hazard_detect u_hazard_detect (
    .ex_valid_i   (valid_q),
    .ex_memread_i (ctrl_q[CTRL_MEMREAD_BIT]),
    .ex_rt_i      (rt_q),
    .id_valid_i   (id_valid),
    .id_rs_i      (id_rs_s),
    .id_rt_i      (id_rt_s),
    .id_uses_rt_i (id_ctrl[CTRL_USESRT_BIT]),
    .flush_i      (flush),
    .hazard_o     (hazard_s),
    .stall_o      (stall)
  );

  // Bubble on flush or load-use; flush has priority but both yield the same bubble.
  always_comb begin
    valid_d = 1'b0;
    ctrl_d  = '0;
    if (flush || hazard_s) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else begin
      valid_d = id_valid;
      ctrl_d  = id_valid ? id_ctrl : '0;
    end
  end

  // Pipeline register; data fields load every cycle since bubbles ignore them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      pc4_q     <= 32'd0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= 5'd0;
      rt_q      <= 5'd0;
      rd_q      <= 5'd0;
      shamt_q   <= 5'd0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      pc4_q     <= id_pc4;
      rs_data_q <= rs_val_s;
      rt_data_q <= rt_val_s;
      imm_q     <= imm_s;
      rs_q      <= id_rs_s;
      rt_q      <= id_rt_s;
      rd_q      <= id_rd_s;
      shamt_q   <= id_shamt_s;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_ctrl    = ctrl_q;
  assign ex_pc4     = pc4_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign ex_shamt   = shamt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents are predicted from the
// driven ID inputs, queued, and checked one cycle later.
module tb_id_ex_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        id_valid;
  logic [31:0] id_instr, id_pc4;
  logic [11:0] id_ctrl;
  logic        id_ext_op;
  logic [31:0] rf_data1, rf_data2;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        flush;
  logic        stall, ex_valid;
  logic [11:0] ex_ctrl;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;

  typedef struct {
    logic        valid;
    logic [11:0] ctrl;
    logic        chk_data;
    logic [31:0] pc4, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd, shamt;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Bench-side view of what EX should hold, used to predict hazards.
  logic        m_valid = 1'b0;
  logic [11:0] m_ctrl  = 12'd0;
  logic [4:0]  m_rt    = 5'd0;

  localparam logic [11:0] C_ADDI = 12'b1000_1000_0000;               // RegWrite, ALUSrc
  localparam logic [11:0] C_LW   = 12'b1101_1000_0000;               // RegWrite, MemRead, MemToReg, ALUSrc
  localparam logic [11:0] C_ADD  = 12'b1000_0111_1101;               // RegWrite, RegDst, ALUOp=FUNC, UsesRt

  id_ex_stage dut (
    .CLK(CLK), .RST_N(RST_N), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc4(id_pc4), .id_ctrl(id_ctrl), .id_ext_op(id_ext_op),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_reg_write(wb_reg_write),
    .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_op(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'd0;
    if (wb_reg_write && wb_write_reg == r) return wb_write_data;
    return rf;
  endfunction

  function automatic logic model_hazard();
    logic [4:0] rs_n, rt_n;
    rs_n = id_instr[25:21];
    rt_n = id_instr[20:16];
    return m_valid && m_ctrl[10] && id_valid && (m_rt != 5'd0) &&
           ((m_rt == rs_n) || ((m_rt == rt_n) && id_ctrl[0]));
  endfunction

  task automatic check_stall(input string tag);
    chk(tag, {31'd0, stall}, {31'd0, model_hazard() && !flush});
  endtask

  // Predict, push, clock, then pop and compare against the DUT.
  task automatic step(input string tag);
    exp_t e, g;
    logic bub;
    bub = flush || model_hazard();
    e.valid    = bub ? 1'b0 : id_valid;
    e.ctrl     = (bub || !id_valid) ? 12'd0 : id_ctrl;
    e.chk_data = !bub;
    e.pc4      = id_pc4;
    e.rs_data  = model_op(id_instr[25:21], rf_data1);
    e.rt_data  = model_op(id_instr[20:16], rf_data2);
    e.imm      = id_ext_op ? {{16{id_instr[15]}}, id_instr[15:0]} : {16'd0, id_instr[15:0]};
    e.rs       = id_instr[25:21];
    e.rt       = id_instr[20:16];
    e.rd       = id_instr[15:11];
    e.shamt    = id_instr[10:6];
    sb_q.push_back(e);
    m_valid = e.valid;
    m_ctrl  = e.ctrl;
    m_rt    = e.rt;
    @(posedge CLK);
    #1;
    g = sb_q.pop_front();
    chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, g.valid});
    chk({tag, ".ctrl"}, {20'd0, ex_ctrl}, {20'd0, g.ctrl});
    if (g.chk_data) begin
      chk({tag, ".pc4"}, ex_pc4, g.pc4);
      chk({tag, ".rs_data"}, ex_rs_data, g.rs_data);
      chk({tag, ".rt_data"}, ex_rt_data, g.rt_data);
      chk({tag, ".imm"}, ex_imm, g.imm);
      chk({tag, ".regs"}, {12'd0, ex_rs, ex_rt, ex_rd, ex_shamt},
          {12'd0, g.rs, g.rt, g.rd, g.shamt});
    end
  endtask

  task automatic present(input logic v, input logic [31:0] ins, input logic [11:0] c,
                         input logic ext, input logic fl);
    id_valid  = v;
    id_instr  = ins;
    id_ctrl   = c;
    id_ext_op = ext;
    flush     = fl;
    id_pc4    = id_pc4 + 32'd4;
    #1;
  endtask

  initial begin
    RST_N = 1'b0; id_valid = 1'b1; id_instr = 32'h2001_0005; id_pc4 = 32'h0000_0100;
    id_ctrl = C_ADDI; id_ext_op = 1'b1; rf_data1 = 32'h99; rf_data2 = 32'h77;
    wb_reg_write = 1'b0; wb_write_reg = 5'd0; wb_write_data = 32'd0; flush = 1'b0;

    // Reset held across clock edges
    repeat (3) @(posedge CLK);
    #1;
    chk("rst.valid", {31'd0, ex_valid}, 32'd0);
    chk("rst.ctrl", {20'd0, ex_ctrl}, 32'd0);
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.data", ex_pc4 | ex_rs_data | ex_rt_data | ex_imm, 32'd0);
    chk("rst.regs", {12'd0, ex_rs, ex_rt, ex_rd, ex_shamt}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // addi $1,$0,5
    present(1'b1, 32'h2001_0005, C_ADDI, 1'b1, 1'b0);
    step("addi");
    chk("addi.imm5", ex_imm, 32'd5);
    chk("addi.rt1", {27'd0, ex_rt}, 32'd1);

    // Sign vs zero extension of 0xFFFC
    present(1'b1, 32'h2001_FFFC, C_ADDI, 1'b1, 1'b0);
    step("sext");
    chk("sext.imm", ex_imm, 32'hFFFF_FFFC);
    present(1'b1, 32'h2001_FFFC, C_ADDI, 1'b0, 1'b0);
    step("zext");
    chk("zext.imm", ex_imm, 32'h0000_FFFC);

    // WB bypass into rs=3 (add $4,$3,$5)
    rf_data1 = 32'h11; rf_data2 = 32'h55;
    wb_reg_write = 1'b1; wb_write_reg = 5'd3; wb_write_data = 32'hABCD;
    present(1'b1, 32'h0065_2020, C_ADD, 1'b1, 1'b0);
    step("byp");
    chk("byp.rs", ex_rs_data, 32'h0000_ABCD);
    chk("byp.rt", ex_rt_data, 32'h55);
    // Write to $0 must never be forwarded
    wb_write_reg = 5'd0; wb_write_data = 32'hDEAD;
    present(1'b1, 32'h0005_2020, C_ADD, 1'b1, 1'b0);
    step("byp0");
    chk("byp0.rs", ex_rs_data, 32'd0);
    wb_reg_write = 1'b0;

    // Load-use: lw $2,0($1) then add $4,$2,$5
    present(1'b1, 32'h8C22_0000, C_LW, 1'b1, 1'b0);
    step("lw1");
    present(1'b1, 32'h0045_2020, C_ADD, 1'b1, 1'b0);
    chk("lu.stall1", {31'd0, stall}, 32'd1);
    check_stall("lu.stall_m");
    step("lu.bubble");
    chk("lu.stall_after", {31'd0, stall}, 32'd0);
    // Re-presented add sees a WB write to $5 this cycle
    wb_reg_write = 1'b1; wb_write_reg = 5'd5; wb_write_data = 32'h1234_5678;
    #1;
    step("lu.add");
    chk("lu.add_rt", ex_rt_data, 32'h1234_5678);
    wb_reg_write = 1'b0;

    // lw $2 followed by addi $2,$6,1 (rt not read)
    present(1'b1, 32'h8C22_0000, C_LW, 1'b1, 1'b0);
    step("lw2");
    present(1'b1, 32'h20C2_0001, C_ADDI, 1'b1, 1'b0);
    chk("nort.stall", {31'd0, stall}, 32'd0);
    step("nort");

    // Flush wins over hazard
    present(1'b1, 32'h8C22_0000, C_LW, 1'b1, 1'b0);
    step("lw3");
    present(1'b1, 32'h0045_2020, C_ADD, 1'b1, 1'b1);
    chk("fl.stall", {31'd0, stall}, 32'd0);
    step("fl.bubble");
    present(1'b0, 32'h0045_2020, C_ADD, 1'b1, 1'b0);
    step("fl.idle");
    chk("fl.idle_ctrl", {20'd0, ex_ctrl}, 32'd0);

    // Reset asserted while stalling
    present(1'b1, 32'h8C22_0000, C_LW, 1'b1, 1'b0);
    step("lw4");
    present(1'b1, 32'h0045_2020, C_ADD, 1'b1, 1'b0);
    chk("mr.stall_pre", {31'd0, stall}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("mr.stall_rst", {31'd0, stall}, 32'd0);
    chk("mr.valid_rst", {31'd0, ex_valid}, 32'd0);
    m_valid = 1'b0; m_ctrl = 12'd0; m_rt = 5'd0;
    RST_N = 1'b1;
    #1;
    step("mr.add");

    // Random-ish captures with bypass on both operands
    for (int i = 0; i < 6; i++) begin
      rf_data1 = $urandom; rf_data2 = $urandom;
      wb_reg_write = 1'($urandom_range(0, 1));
      wb_write_reg = 5'($urandom_range(0, 7));
      wb_write_data = $urandom;
      present(1'b1, {6'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     16'($urandom)}, C_ADD, 1'($urandom_range(0, 1)), 1'b0);
      check_stall("rnd.stall");
      step("rnd");
    end

    chk("sb.empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage sitting directly downstream of the register file in the five-stage MIPS core.
- Registers the operands read from the register file, the extended immediate, the decoded control bundle and the register numbers for EX.
- Bypasses a same-cycle WB write into the ID operands.
- Detects load-use hazards, inserting one bubble and stalling PC and IF/ID.

Parameters:
- DATA_W, 32, datapath width.
- CTRL_W, 12, width of the decoded control bundle (RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[3:0], Branch, UsesRt).
- CTRL_MEMREAD_BIT, 10, bit index of MemRead within the control bundle.
- CTRL_USESRT_BIT, 0, bit index of UsesRt within the control bundle.

Ports:
- CLK  in  1  clock; all state updates on the posedge.
- RST_N  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_instr  in  32  instruction word from IF/ID.
- id_pc4  in  32  PC+4 of the instruction.
- id_ctrl  in  CTRL_W  decoded control bundle.
- id_ext_op  in  1  1 = sign-extend imm16, 0 = zero-extend.
- rf_data1  in  DATA_W  register file readData1 (rs).
- rf_data2  in  DATA_W  register file readData2 (rt).
- wb_reg_write  in  1  WB write enable (same signal driven to RegWrite).
- wb_write_reg  in  5  WB destination register.
- wb_write_data  in  DATA_W  WB write data.
- flush  in  1  branch/jump redirect from EX/MEM.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_ctrl  out  CTRL_W  registered control bundle.
- ex_pc4  out  32  registered PC+4.
- ex_rs_data  out  DATA_W  registered rs operand.
- ex_rt_data  out  DATA_W  registered rt operand.
- ex_imm  out  DATA_W  registered extended immediate.
- ex_rs, ex_rt, ex_rd  out  5 each  registered register numbers (instr[25:21], [20:16], [15:11]).
- ex_shamt  out  5  registered instr[10:6].

Behaviour:
- Reset (RST_N low, asynchronous): all outputs are 0, including ex_valid=0 and ex_ctrl=0. stall is 0 while in reset. Effect is immediate; no clock required.
- Register number fields: rs=id_instr[25:21], rt=id_instr[20:16].
- Operand bypass (combinational, feeding the capture):
  - rs value = 0 if rs==0.
  - else wb_write_data if wb_reg_write && wb_write_reg==rs.
  - else rf_data1.
  - The rt value uses the same rule with rf_data2.
  - Purpose: the register file writes at the posedge, so a same-cycle WB write is not yet visible on its read ports.
- Immediate:
  - id_ext_op=1: {{16{instr[15]}}, instr[15:0]}.
  - id_ext_op=0: {16'b0, instr[15:0]}.
- Load-use hazard is asserted when all of the following hold:
  - ex_valid
  - ex_ctrl[CTRL_MEMREAD_BIT]
  - id_valid
  - ex_rt != 0
  - ex_rt == rs, OR (ex_rt == rt AND id_ctrl[CTRL_USESRT_BIT])
- stall = hazard && !flush. Purely combinational.
- Posedge update, in priority order:
  1. flush: bubble. ex_valid←0, ex_ctrl←0; data fields may update (don't care).
  2. hazard: bubble. ex_valid←0, ex_ctrl←0. IF/ID is held upstream, so the same ID instruction is re-presented next cycle.
  3. otherwise: capture. ex_valid←id_valid, ex_ctrl←(id_valid ? id_ctrl : 0), all data fields captured.
- A hazard lasts exactly one cycle, because the bubble clears MemRead in EX. Back-to-back loads with a dependent third instruction stall once per dependent pair.
- Simultaneous flush and hazard: flush wins and stall=0.
- Reset mid-stall: stall drops immediately; after release the first posedge captures normally.
- Bypass applies equally to the re-presented instruction after a stall.
- No multi-cycle state beyond the pipeline register; latency ID→EX is 1 cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - Control-bundle bit index constants (CTRL_* positions, CTRL_W).
  - Instruction field position constants.
  - ALUOp encodings.
- One natural sub-module: hazard_detect, the combinational load-use detector that produces stall. It is reused later by the branch-in-ID logic.
- The bypass mux and immediate extension stay inline.

Test Plan:
- Reset: hold RST_N=0 and toggle CLK → all ex_* outputs 0, stall=0. Release, present addi $1,$0,5 (0x20010005), ctrl valid → next posedge ex_imm=5, ex_rt=1, ex_valid=1.
- Sign extension: instr imm 0xFFFC with ext_op=1 → ex_imm=0xFFFFFFFC. Same with ext_op=0 → 0x0000FFFC.
- WB bypass: rf_data1=0x11, rs=3, wb_reg_write=1, wb_write_reg=3, wb_write_data=0xABCD → ex_rs_data=0xABCD.
  - With wb_write_reg=0 and rs=0 → ex_rs_data=0.
- Load-use: EX holds lw $2 (MemRead=1, ex_rt=2) and ID holds add $4,$2,$5 → stall=1 for one cycle, next ex_valid=0, ex_ctrl=0. The following cycle captures the add with stall=0.
- Non-use of rt: EX lw $2, ID addi $2,$6,1 (UsesRt=0, rs=6) → stall=0.
- Flush priority: hazard condition true and flush=1 → stall=0, next ex_valid=0. Then id_valid=0 → ex_ctrl stays 0.
